// File: rtl/bank_cmd_fifo.sv
// Multi-channel command queue: one show-ahead FIFO per DRAM bank behind a shared write port.
// Optional per-channel synchronous flush is enabled by defining BANK_CMD_FIFO_FLUSH_EN.
module bank_cmd_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH_LOG2 = 4,
    parameter  int NUM_CH     = 4,
    parameter  int AFULL_LEFT = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = DEPTH_LOG2 + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [CH_W-1:0]              i_wr_ch,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [NUM_CH-1:0]            i_rd_en,
    input  logic                         i_clr_err,
`ifdef BANK_CMD_FIFO_FLUSH_EN
    input  logic [NUM_CH-1:0]            i_flush,
`endif
    output logic [NUM_CH*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_CH-1:0]            o_empty,
    output logic [NUM_CH-1:0]            o_full,
    output logic [NUM_CH-1:0]            o_almost_full,
    output logic [NUM_CH*CNT_W-1:0]      o_count,
    output logic [NUM_CH-1:0]            o_overflow,
    output logic [NUM_CH-1:0]            o_underflow
);

    localparam int               DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] AFULL_TH = CNT_W'(DEPTH - AFULL_LEFT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            logic [CNT_W-1:0] wr_ptr_reg, wr_ptr_next;
            logic [CNT_W-1:0] rd_ptr_reg, rd_ptr_next;
            logic [CNT_W-1:0] count_reg, count_next;
            logic             empty_reg, empty_next;
            logic             full_reg, full_next;
            logic             afull_reg, afull_next;
            logic             ovf_reg, ovf_next;
            logic             udf_reg, udf_next;
            logic             wr_sel, flush, wr_acc, rd_acc;

            // Out-of-range channel numbers never match any gi, so those writes just vanish.
            assign wr_sel = i_wr_en && (i_wr_ch == CH_W'(gi));
`ifdef BANK_CMD_FIFO_FLUSH_EN
            assign flush  = i_flush[gi];
`else
            assign flush  = 1'b0;
`endif
            // Acceptance uses the registered flags: a full queue refuses a write even when popped.
            assign wr_acc = wr_sel && !full_reg && !flush;
            assign rd_acc = i_rd_en[gi] && !empty_reg && !flush;

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                if (flush) begin
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                end else begin
                    if (wr_acc) wr_ptr_next = wr_ptr_reg + ONE;
                    if (rd_acc) rd_ptr_next = rd_ptr_reg + ONE;
                end
                count_next = wr_ptr_next - rd_ptr_next;
                empty_next = (wr_ptr_next == rd_ptr_next);
                full_next  = (wr_ptr_next == {~rd_ptr_next[CNT_W-1], rd_ptr_next[CNT_W-2:0]});
                afull_next = (count_next >= AFULL_TH);

                // A fresh error in the clearing cycle must survive, so set is applied last.
                ovf_next = i_clr_err ? 1'b0 : ovf_reg;
                udf_next = i_clr_err ? 1'b0 : udf_reg;
                if (wr_sel && full_reg && !flush)       ovf_next = 1'b1;
                if (i_rd_en[gi] && empty_reg && !flush) udf_next = 1'b1;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    empty_reg  <= 1'b1;
                    full_reg   <= 1'b0;
                    afull_reg  <= 1'b0;
                    ovf_reg    <= 1'b0;
                    udf_reg    <= 1'b0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                    empty_reg  <= empty_next;
                    full_reg   <= full_next;
                    afull_reg  <= afull_next;
                    ovf_reg    <= ovf_next;
                    udf_reg    <= udf_next;
                end
            end

            // Storage carries no reset; stale words are masked by the empty flag.
            always_ff @(posedge i_clk) begin
                if (wr_acc) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= i_wr_data;
            end

            assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
            assign o_count[gi*CNT_W +: CNT_W]             = count_reg;
            assign o_empty[gi]                            = empty_reg;
            assign o_full[gi]                             = full_reg;
            assign o_almost_full[gi]                      = afull_reg;
            assign o_overflow[gi]                         = ovf_reg;
            assign o_underflow[gi]                        = udf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bank_cmd_fifo.sv
// Self-checking bench for bank_cmd_fifo: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model every cycle.
module tb_bank_cmd_fifo;

    localparam int DW = 32;
    localparam int DL = 4;
    localparam int NC = 4;
    localparam int AL = 4;
    localparam int CW = DL + 1;
    localparam int D  = 1 << DL;

    logic            i_clk;
    logic            i_rst;
    logic            i_wr_en;
    logic [1:0]      i_wr_ch;
    logic [DW-1:0]   i_wr_data;
    logic [NC-1:0]   i_rd_en;
    logic            i_clr_err;
`ifdef BANK_CMD_FIFO_FLUSH_EN
    logic [NC-1:0]   i_flush;
`endif
    logic [NC*DW-1:0] o_rd_data;
    logic [NC-1:0]    o_empty;
    logic [NC-1:0]    o_full;
    logic [NC-1:0]    o_almost_full;
    logic [NC*CW-1:0] o_count;
    logic [NC-1:0]    o_overflow;
    logic [NC-1:0]    o_underflow;

    bank_cmd_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .NUM_CH     (NC),
        .AFULL_LEFT (AL)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_en       (i_wr_en),
        .i_wr_ch       (i_wr_ch),
        .i_wr_data     (i_wr_data),
        .i_rd_en       (i_rd_en),
        .i_clr_err     (i_clr_err),
`ifdef BANK_CMD_FIFO_FLUSH_EN
        .i_flush       (i_flush),
`endif
        .o_rd_data     (o_rd_data),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: one queue of words per channel plus sticky flags.
    logic [DW-1:0] mq [NC][$];
    logic          m_ovf [NC];
    logic          m_udf [NC];

    typedef struct {
        logic          wr_en;
        logic [1:0]    wr_ch;
        logic [DW-1:0] wr_data;
        logic [NC-1:0] rd_en;
        logic          clr;
        int            ch;
        int            exp_count;
        logic          exp_empty;
        logic          chk_head;
        logic [DW-1:0] exp_head;
        logic          exp_udf;
    } vec_t;

    vec_t vt [10];

    function automatic int dut_count(input int c);
        return int'(o_count[c*CW +: CW]);
    endfunction

    function automatic logic [DW-1:0] dut_head(input int c);
        return o_rd_data[c*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            m_ovf[c] = 1'b0;
            m_udf[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic we, input logic [1:0] ch, input logic [DW-1:0] d,
                              input logic [NC-1:0] re, input logic clr, input logic [NC-1:0] fl);
        for (int c = 0; c < NC; c++) begin
            int  sz;
            logic set_o, set_u;
            sz    = mq[c].size();
            set_o = 1'b0;
            set_u = 1'b0;
            if (fl[c]) begin
                mq[c].delete();
            end else begin
                set_o = we && (int'(ch) == c) && (sz == D);
                set_u = re[c] && (sz == 0);
                if (re[c] && sz > 0) void'(mq[c].pop_front());
                if (we && int'(ch) == c && sz < D) mq[c].push_back(d);
            end
            if (clr) begin
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end
            if (set_o) m_ovf[c] = 1'b1;
            if (set_u) m_udf[c] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NC; c++) begin
            int sz;
            sz = mq[c].size();
            chk($sformatf("ch%0d count", c), DW'(dut_count(c)), DW'(sz));
            chk($sformatf("ch%0d empty", c), DW'(o_empty[c]), DW'(sz == 0));
            chk($sformatf("ch%0d full", c), DW'(o_full[c]), DW'(sz == D));
            chk($sformatf("ch%0d afull", c), DW'(o_almost_full[c]), DW'(sz >= D - AL));
            chk($sformatf("ch%0d overflow", c), DW'(o_overflow[c]), DW'(m_ovf[c]));
            chk($sformatf("ch%0d underflow", c), DW'(o_underflow[c]), DW'(m_udf[c]));
            if (sz > 0) chk($sformatf("ch%0d head", c), dut_head(c), mq[c][0]);
        end
    endtask

    task automatic set_idle();
        i_wr_en   = 1'b0;
        i_wr_ch   = '0;
        i_wr_data = '0;
        i_rd_en   = '0;
        i_clr_err = 1'b0;
`ifdef BANK_CMD_FIFO_FLUSH_EN
        i_flush   = '0;
`endif
    endtask

    // Drive one cycle, advance the model with the same inputs, then compare 1 time unit after the edge.
    task automatic step(input logic we, input logic [1:0] ch, input logic [DW-1:0] d,
                        input logic [NC-1:0] re, input logic clr, input logic [NC-1:0] fl);
        logic [NC-1:0] fl_eff;
        i_wr_en   = we;
        i_wr_ch   = ch;
        i_wr_data = d;
        i_rd_en   = re;
        i_clr_err = clr;
`ifdef BANK_CMD_FIFO_FLUSH_EN
        i_flush   = fl;
        fl_eff    = fl;
`else
        fl_eff    = '0;
`endif
        @(posedge i_clk);
        model_step(we, ch, d, re, clr, fl_eff);
        #1;
        set_idle();
        check_all();
    endtask

    initial begin
        set_idle();
        i_rst = 1'b1;
        model_reset();
        #3;
        check_all();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Order/count on ch2, then underflow and clear on ch0.
        vt[0] = '{1'b1, 2'd2, 32'hA0, 4'b0000, 1'b0, 2, 1, 1'b0, 1'b1, 32'hA0, 1'b0};
        vt[1] = '{1'b1, 2'd2, 32'hA1, 4'b0000, 1'b0, 2, 2, 1'b0, 1'b1, 32'hA0, 1'b0};
        vt[2] = '{1'b1, 2'd2, 32'hA2, 4'b0000, 1'b0, 2, 3, 1'b0, 1'b1, 32'hA0, 1'b0};
        vt[3] = '{1'b0, 2'd0, 32'h00, 4'b0100, 1'b0, 2, 2, 1'b0, 1'b1, 32'hA1, 1'b0};
        vt[4] = '{1'b0, 2'd0, 32'h00, 4'b0100, 1'b0, 2, 1, 1'b0, 1'b1, 32'hA2, 1'b0};
        vt[5] = '{1'b0, 2'd0, 32'h00, 4'b0100, 1'b0, 2, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        vt[6] = '{1'b0, 2'd0, 32'h00, 4'b0001, 1'b0, 0, 0, 1'b1, 1'b0, 32'h00, 1'b1};
        vt[7] = '{1'b0, 2'd0, 32'h00, 4'b0000, 1'b1, 0, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        vt[8] = '{1'b0, 2'd0, 32'h00, 4'b0001, 1'b1, 0, 0, 1'b1, 1'b0, 32'h00, 1'b1};
        vt[9] = '{1'b0, 2'd0, 32'h00, 4'b0000, 1'b1, 0, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].wr_en, vt[i].wr_ch, vt[i].wr_data, vt[i].rd_en, vt[i].clr, '0);
            chk($sformatf("vec%0d count", i), DW'(dut_count(vt[i].ch)), DW'(vt[i].exp_count));
            chk($sformatf("vec%0d empty", i), DW'(o_empty[vt[i].ch]), DW'(vt[i].exp_empty));
            chk($sformatf("vec%0d underflow", i), DW'(o_underflow[vt[i].ch]), DW'(vt[i].exp_udf));
            if (vt[i].chk_head) chk($sformatf("vec%0d head", i), dut_head(vt[i].ch), vt[i].exp_head);
        end

        // Fill ch1 to full, then overflow it.
        for (int i = 1; i <= D; i++) begin
            step(1'b1, 2'd1, 32'hB0 + DW'(i - 1), '0, 1'b0, '0);
            chk($sformatf("fill%0d afull", i), DW'(o_almost_full[1]), DW'(i >= 12));
            chk($sformatf("fill%0d full", i), DW'(o_full[1]), DW'(i == 16));
        end
        step(1'b1, 2'd1, 32'hDEAD, '0, 1'b0, '0);
        chk("ovf17 overflow", DW'(o_overflow[1]), 32'd1);
        chk("ovf17 count", DW'(dut_count(1)), 32'd16);
        chk("ovf17 head", dut_head(1), 32'hB0);
        for (int i = 0; i < D; i++) step(1'b0, 2'd0, '0, 4'b0010, 1'b0, '0);
        step(1'b0, 2'd0, '0, '0, 1'b1, '0);

        // Simultaneous read/write on ch3 at count 5, 16 and 0.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd3, 32'hC0 + DW'(i), '0, 1'b0, '0);
        step(1'b1, 2'd3, 32'hC5, 4'b1000, 1'b0, '0);
        chk("rw5 count", DW'(dut_count(3)), 32'd5);
        chk("rw5 head", dut_head(3), 32'hC1);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd0, '0, 4'b1000, 1'b0, '0);
        for (int i = 0; i < D; i++) step(1'b1, 2'd3, 32'hD0 + DW'(i), '0, 1'b0, '0);
        step(1'b1, 2'd3, 32'hEEEE, 4'b1000, 1'b0, '0);
        chk("rw16 count", DW'(dut_count(3)), 32'd15);
        chk("rw16 overflow", DW'(o_overflow[3]), 32'd1);
        chk("rw16 head", dut_head(3), 32'hD1);
        for (int i = 0; i < 15; i++) step(1'b0, 2'd0, '0, 4'b1000, 1'b0, '0);
        step(1'b1, 2'd3, 32'hF0, 4'b1000, 1'b0, '0);
        chk("rw0 count", DW'(dut_count(3)), 32'd1);
        chk("rw0 underflow", DW'(o_underflow[3]), 32'd1);
        chk("rw0 head", dut_head(3), 32'hF0);
        step(1'b0, 2'd0, '0, 4'b1000, 1'b1, '0);

        // Asynchronous reset mid-stream with ch0 holding 7 entries.
        for (int i = 0; i < 7; i++) step(1'b1, 2'd0, 32'h70 + DW'(i), '0, 1'b0, '0);
        chk("pre-rst count", DW'(dut_count(0)), 32'd7);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async-rst empty", DW'(o_empty[0]), 32'd1);
        chk("async-rst count", DW'(dut_count(0)), 32'd0);
        model_reset();
        check_all();
        #2;
        i_rst = 1'b0;

`ifdef BANK_CMD_FIFO_FLUSH_EN
        // Flush ch2 at count 9 together with a write and a read to it.
        for (int i = 0; i < 9; i++) step(1'b1, 2'd2, 32'h90 + DW'(i), '0, 1'b0, '0);
        step(1'b1, 2'd2, 32'h99, 4'b0100, 1'b0, 4'b0100);
        chk("flush count", DW'(dut_count(2)), 32'd0);
        chk("flush empty", DW'(o_empty[2]), 32'd1);
        chk("flush overflow", DW'(o_overflow[2]), 32'd0);
        chk("flush underflow", DW'(o_underflow[2]), 32'd0);
        step(1'b0, 2'd0, '0, 4'b0100, 1'b0, '0);
        chk("post-flush underflow", DW'(o_underflow[2]), 32'd1);
`endif

        // Randomized traffic: write-heavy phase then read-heavy phase.
        for (int i = 0; i < 3000; i++) begin
            logic          we, clr;
            logic [1:0]    ch;
            logic [NC-1:0] re, fl;
            int            rd_pct;
            rd_pct = (i < 1500) ? 8 : 45;
            we  = ($urandom_range(0, 99) < 70);
            ch  = 2'($urandom_range(0, NC - 1));
            for (int c = 0; c < NC; c++) re[c] = ($urandom_range(0, 99) < rd_pct);
            clr = ($urandom_range(0, 59) == 0);
            fl  = '0;
`ifdef BANK_CMD_FIFO_FLUSH_EN
            if ($urandom_range(0, 99) == 0) fl = NC'($urandom_range(0, (1 << NC) - 1));
`endif
            step(we, ch, $urandom, re, clr, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bank_cmd_fifo.md
Name: bank_cmd_fifo

Overview:
Multi-channel synchronous command queue, one independent FIFO per DRAM bank (channel). It sits between the frontend command decoder and the per-bank schedulers. A shared write port with a channel select fills the queues. Each channel has its own show-ahead read port, occupancy count, almost-full flag and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 32, command word width in bits.
- DEPTH_LOG2, 4, log2 of per-channel depth; depth D = 2^DEPTH_LOG2.
- NUM_CH, 4, number of channels (banks); legal range 1..16.
- AFULL_LEFT, 4, almost-full asserts when free slots <= AFULL_LEFT; legal range 1..D-1.
- Derived CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1.
- Derived CNT_W = DEPTH_LOG2 + 1.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_wr_en  in  1  write request.
- i_wr_ch  in  CH_W  target channel of the write.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd_en  in  NUM_CH  per-channel read (pop) request.
- i_clr_err  in  1  synchronous clear of all sticky error flags.
- o_rd_data  out  NUM_CH*DATA_WIDTH  head entry of channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- o_empty  out  NUM_CH  channel empty.
- o_full  out  NUM_CH  channel full.
- o_almost_full  out  NUM_CH  channel almost full.
- o_count  out  NUM_CH*CNT_W  channel occupancy, 0..D.
- o_overflow  out  NUM_CH  sticky: write attempted while full.
- o_underflow  out  NUM_CH  sticky: read attempted while empty.

Behaviour:
- Per channel: wr_ptr and rd_ptr are CNT_W bits wide and wrap naturally.
  - Memory is indexed by the low DEPTH_LOG2 bits.
  - Occupancy = wr_ptr - rd_ptr, computed modulo 2^CNT_W.
- Reset (i_rst=1, asynchronous, takes effect with no clock edge):
  - All pointers 0; o_empty all 1; o_full 0; o_almost_full 0; o_count 0; o_overflow 0; o_underflow 0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all queued entries immediately.
- Write acceptance: wr_acc = i_wr_en && i_wr_ch < NUM_CH && !o_full[i_wr_ch].
  - On acceptance: mem[i_wr_ch][wr_ptr] <= i_wr_data, and that channel's wr_ptr increments.
  - A write with i_wr_ch >= NUM_CH is dropped silently, with no flag.
- Read acceptance: rd_acc[c] = i_rd_en[c] && !o_empty[c]. On acceptance rd_ptr[c] increments.
- o_rd_data[c] is combinational from mem at rd_ptr[c] (show-ahead, zero read latency). Its value is undefined while o_empty[c]=1.
- Flags and count are registered, computed from next-state pointers, so they reflect the state after the edge:
  - empty when n_wr == n_rd.
  - full when n_wr == {~n_rd[MSB], n_rd[MSB-1:0]}.
  - almost_full when (n_wr - n_rd) >= D - AFULL_LEFT.
- Simultaneous read and write on one channel:
  - Non-empty and non-full: both accepted, count unchanged.
  - Empty: write accepted, read rejected.
  - Full: read accepted, write rejected. full is the registered value and blocks the write even though a slot frees this cycle.
- Sticky errors:
  - o_overflow[c] sets when i_wr_en && i_wr_ch==c && o_full[c].
  - o_underflow[c] sets when i_rd_en[c] && o_empty[c].
  - i_clr_err clears all flags on the next edge. A set condition in the same cycle wins over the clear.
- Rejected operations never change pointers or storage.
- Channels are fully independent; activity on one channel never alters another channel's state.

Optional Feature:
- Macro: BANK_CMD_FIFO_FLUSH_EN.
- Defined: adds port i_flush, input, NUM_CH bits, synchronous flush per channel.
  - On the edge with i_flush[c]=1, both pointers of channel c go to 0, o_empty[c]=1, o_count[c]=0, o_full[c]=0, o_almost_full[c]=0.
  - Flush has priority over a read or write to c in the same cycle; that read or write is discarded and sets no error flag.
- Undefined: i_flush does not exist; behaviour is exactly as above.

Test Plan (DATA_WIDTH=32, DEPTH_LOG2=4, NUM_CH=4, AFULL_LEFT=4):
1. Order and count: after reset, write 0xA0, 0xA1, 0xA2 to ch2 on consecutive cycles.
   - Required: o_count[2]=3 and o_rd_data[2]=0xA0.
   - Pop 3 times; data reads 0xA0, 0xA1, 0xA2 in order.
   - o_empty[2]=1 the cycle after the last pop; ch0, ch1 and ch3 stay empty throughout.
2. Fill and overflow: write 16 entries to ch1.
   - o_almost_full[1] rises after the 12th write; o_full[1] rises after the 16th.
   - A 17th write is dropped, o_overflow[1]=1, o_count[1]=16, and the head is still the first entry.
3. Underflow and clear: pulse i_rd_en[0] on empty ch0.
   - o_underflow[0]=1 and o_count[0]=0.
   - Pulse i_clr_err alone: flag is 0 next cycle.
   - Pulse i_clr_err together with a fresh underflow: flag stays 1.
4. Simultaneous read and write, ch3:
   - At count 5: count stays 5 and FIFO order is preserved.
   - At count 16: count becomes 15, the write is dropped, o_overflow[3]=1.
   - At count 0: count becomes 1, o_underflow[3]=1.
5. Reset mid-stream: with ch0 count 7, assert i_rst between clock edges.
   - o_empty[0]=1 and o_count[0]=0 immediately, with no clock edge.
6. Flush (BANK_CMD_FIFO_FLUSH_EN defined): ch2 at count 9; assert i_flush[2] together with a write to ch2.
   - Next cycle ch2 count is 0 and empty, the write is discarded, and no error flag is set.
